ppm_freq_loop_filter: RTL
=========================

Name: ppm_freq_loop_filter

Overview:
Downstream of the PPM frequency-recovery counter stage. Takes each interpulse cycle-count measurement taken during the preamble and compares it with the expected spacing. From the error it steps an oscillator-trim DAC code, waiting for the oscillator to settle after every step. Asserts freq_ok once enough consecutive in-tolerance measurements arrive; freq_ok is fed back to gate the recovery stage.

Parameters:
SYMBOL_CHIPS, 16, chips per symbol; measurement width W = `ceilLog2(SYMBOL_CHIPS)+1
DAC_BITS, 6, trim DAC code width
TOLERANCE, 1, max |error| in cycles counted as in-tolerance
LOCK_COUNT, 4, consecutive in-tolerance measurements required for lock (>=1)
SETTLE_CYCLES, 4, cycles measurements are ignored after each DAC step (>=1)
GAIN_SHIFT, 1, arithmetic right shift applied to error to form DAC step
TIMEOUT_CYCLES, 1024, acquire watchdog length (used only with PPM_FLF_TIMEOUT_EN)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
enable  in  1  loop enable; low forces IDLE
meas_valid  in  1  one-cycle strobe: interpulse_cycles/intrasymbol_pulses are new
interpulse_cycles  in  W  measured cycles between pulses; all-ones = saturated
intrasymbol_pulses  in  2  pulses seen in last symbol; 2'b11 = noisy
expected_cycles  in  W  target interpulse spacing
dac_code  out  DAC_BITS  oscillator trim code
dac_update  out  1  one-cycle pulse when dac_code changes
dac_sat  out  1  last step clamped at 0 or full scale
freq_ok  out  1  frequency locked
timeout  out  1  sticky acquire timeout flag (tied 0 without macro)
FLF_state_SC  out  2  FSM state
FLF_in_tol_count_SC  out  ceilLog2(LOCK_COUNT)+1  consecutive in-tolerance count
FLF_error_SC  out  W+1  last signed error

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: state IDLE, dac_code = 2^(DAC_BITS-1), dac_update 0, dac_sat 0, freq_ok 0, timeout 0, in_tol_count 0, error 0.
- States: IDLE=0, ACQUIRE=1, SETTLE=2, LOCKED=3.
- IDLE: enable high -> ACQUIRE next cycle. dac_code holds its last value; re-acquisition starts from it.
- ACQUIRE: on meas_valid, the measurement is discarded (no state or count change) if interpulse_cycles is all-ones or intrasymbol_pulses==2'b11.
- Otherwise error = interpulse_cycles - expected_cycles, signed W+1 bits, registered into FLF_error_SC.
- |error|<=TOLERANCE: in_tol_count+1; the LOCK_COUNT-th consecutive hit -> LOCKED, freq_ok=1 the following cycle.
- |error|>TOLERANCE: in_tol_count=0; step = error>>>GAIN_SHIFT, forced to +/-1 if the shift yields 0.
- New dac_code = dac_code - step, clamped to [0, 2^DAC_BITS-1]. dac_sat = clamp occurred.
- dac_code and dac_update are registered: measurement in cycle N -> new code and a 1-cycle dac_update in N+1. State -> SETTLE.
- Sign convention: positive error (local clock fast) lowers the code.
- SETTLE: counts SETTLE_CYCLES cycles, ignoring meas_valid, then -> ACQUIRE.
- LOCKED: DAC frozen, freq_ok held 1, meas_valid ignored.
- enable low in any state -> IDLE next cycle: freq_ok 0, in_tol_count 0, settle counter cleared, dac_code held.
- enable low wins over a simultaneous meas_valid.
- Reset mid-operation restores all reset values regardless of state.

Optional Feature:
- Macro PPM_FLF_TIMEOUT_EN.
- Defined: a watchdog counts cycles spent in ACQUIRE/SETTLE since leaving IDLE or LOCKED, and clears on entry to LOCKED. On reaching TIMEOUT_CYCLES: dac_code returns to midscale with a dac_update pulse, in_tol_count clears, state -> SETTLE, and timeout sets. timeout is sticky until reset or enable low.
- Undefined: no watchdog, timeout tied 0.

Decomposition:
- Shared header (with the existing chip constants and the `ceilLog2 macro): state encodings and the measurement-width macro.
- One natural sub-module, ppm_flf_dac_step: combinational error -> shifted step -> clamped next code plus saturation flag.

Test Plan:
Defaults for all cases: W=5, expected_cycles=8, midscale 32.
- Reset held 2 cycles -> dac_code=32, freq_ok=0, FLF_state_SC=0, dac_update=0.
- enable=1, meas 12 -> error +4, step 2, dac_code=30 with dac_update pulse next cycle; a meas 2 cycles later is ignored (still SETTLE).
- Four meas of 9, each after settle -> dac_code stays 32, freq_ok=1 one cycle after the 4th; later meas 20 changes nothing.
- dac_code at 62, meas 0 -> error -8, step -4 -> dac_code=63, dac_sat=1.
- Meas 31 (saturated) and meas 8 with intrasymbol_pulses=3 -> no dac_update, FLF_in_tol_count_SC unchanged.
- enable dropped during SETTLE -> IDLE next cycle, freq_ok=0, dac_code held. With PPM_FLF_TIMEOUT_EN and no meas for 1024 cycles -> dac_code=32, timeout=1.

Source files
------------

// File: rtl/ppm_freq_loop_filter_pkg.sv
// Shared definitions for the PPM frequency loop filter: chip constants, width helpers, FSM encoding.
// Optional watchdog in the top is enabled with PPM_FLF_TIMEOUT_EN.
`ifndef PPM_FLF_DEFS_SVH
`define PPM_FLF_DEFS_SVH
`define ceilLog2(x) ($clog2(x))
`define PPM_MEAS_W(chips) (`ceilLog2(chips) + 1)
`endif

package ppm_freq_loop_filter_pkg;

    localparam int PPM_SYMBOL_CHIPS = 16;
    localparam int PPM_CHIP_STATES  = 2;

    function automatic int ceil_log2(input int x);
        return $clog2(x);
    endfunction

    // Interpulse count width: one extra bit above the symbol length so all-ones marks saturation.
    function automatic int meas_width(input int chips);
        return ceil_log2(chips) + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_LOCKED  = 2'd3
    } flf_state_t;

endpackage

// File: rtl/ppm_freq_loop_filter_dac_step.sv
// Combinational trim step: signed error -> shifted step (never zero) -> next DAC code clamped to range.
module ppm_flf_dac_step #(
    parameter int ERR_W      = 6,
    parameter int DAC_BITS   = 6,
    parameter int GAIN_SHIFT = 1
) (
    input  logic signed [ERR_W-1:0]    error,
    input  logic        [DAC_BITS-1:0] code,
    output logic        [DAC_BITS-1:0] code_next,
    output logic                       sat
);

    localparam int SUM_W = ((ERR_W > DAC_BITS) ? ERR_W : DAC_BITS) + 2;
    localparam logic signed [SUM_W-1:0] CODE_MAX = SUM_W'((1 << DAC_BITS) - 1);

    // A small error must still move the code, so a zero shift result becomes +/-1.
    function automatic logic signed [SUM_W-1:0] dac_step(input logic signed [ERR_W-1:0] e);
        logic signed [ERR_W-1:0] s;
        s = e >>> GAIN_SHIFT;
        if (s == '0) begin
            s = e[ERR_W-1] ? '1 : ERR_W'(1);
        end
        return {{(SUM_W-ERR_W){s[ERR_W-1]}}, s};
    endfunction

    function automatic logic [DAC_BITS:0] clamp_code(input logic signed [SUM_W-1:0] v);
        if (v < 0) begin
            return {1'b1, {DAC_BITS{1'b0}}};
        end else if (v > CODE_MAX) begin
            return {1'b1, {DAC_BITS{1'b1}}};
        end else begin
            return {1'b0, v[DAC_BITS-1:0]};
        end
    endfunction

    logic signed [SUM_W-1:0] code_ext;
    logic signed [SUM_W-1:0] sum;

    assign code_ext         = {{(SUM_W-DAC_BITS){1'b0}}, code};
    assign sum              = code_ext - dac_step(error);
    assign {sat, code_next} = clamp_code(sum);

endmodule

// File: rtl/ppm_freq_loop_filter.sv
// PPM frequency loop filter: steps an oscillator trim DAC from preamble interpulse errors until lock.
// Define PPM_FLF_TIMEOUT_EN to add the acquire watchdog that re-centres the DAC and flags timeout.
module ppm_freq_loop_filter
    import ppm_freq_loop_filter_pkg::*;
#(
    parameter int SYMBOL_CHIPS   = 16,
    parameter int DAC_BITS       = 6,
    parameter int TOLERANCE      = 1,
    parameter int LOCK_COUNT     = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int GAIN_SHIFT     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   meas_valid,
    input  logic [meas_width(SYMBOL_CHIPS)-1:0]    interpulse_cycles,
    input  logic [1:0]                             intrasymbol_pulses,
    input  logic [meas_width(SYMBOL_CHIPS)-1:0]    expected_cycles,
    output logic [DAC_BITS-1:0]                    dac_code,
    output logic                                   dac_update,
    output logic                                   dac_sat,
    output logic                                   freq_ok,
    output logic                                   timeout,
    output logic [1:0]                             FLF_state_SC,
    output logic [ceil_log2(LOCK_COUNT):0]         FLF_in_tol_count_SC,
    output logic signed [meas_width(SYMBOL_CHIPS):0] FLF_error_SC
);

    localparam int W     = meas_width(SYMBOL_CHIPS);
    localparam int CNT_W = ceil_log2(LOCK_COUNT) + 1;
    localparam int SET_W = ceil_log2(SETTLE_CYCLES) + 1;

    localparam logic [DAC_BITS-1:0] DAC_MID     = {1'b1, {(DAC_BITS-1){1'b0}}};
    localparam logic [W:0]          TOL         = (W+1)'(TOLERANCE);
    localparam logic [CNT_W-1:0]    LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
    localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    if (LOCK_COUNT < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ppm_freq_loop_filter: LOCK_COUNT, SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    flf_state_t              state, state_next;
    logic [DAC_BITS-1:0]     dac_q, dac_next;
    logic                    update_q, update_next;
    logic                    sat_q, sat_next;
    logic                    freq_ok_q, freq_ok_next;
    logic [CNT_W-1:0]        cnt_q, cnt_next;
    logic signed [W:0]       err_q, err_next;
    logic [SET_W-1:0]        settle_q, settle_next;

    logic signed [W:0]       meas_err;
    logic [W:0]              err_mag;
    logic                    meas_bad;
    logic                    in_tol;
    logic [DAC_BITS-1:0]     step_code;
    logic                    step_sat;

    assign meas_err = $signed({1'b0, interpulse_cycles}) - $signed({1'b0, expected_cycles});
    assign err_mag  = meas_err[W] ? -meas_err : meas_err;
    assign in_tol   = (err_mag <= TOL);
    assign meas_bad = (&interpulse_cycles) || (intrasymbol_pulses == 2'b11);

    ppm_flf_dac_step #(
        .ERR_W      (W + 1),
        .DAC_BITS   (DAC_BITS),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_dac_step (
        .error     (meas_err),
        .code      (dac_q),
        .code_next (step_code),
        .sat       (step_sat)
    );

`ifdef PPM_FLF_TIMEOUT_EN
    localparam int WD_W = ceil_log2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_next;
    logic            timeout_q, timeout_next;
`endif

    always_comb begin
        state_next   = state;
        dac_next     = dac_q;
        update_next  = 1'b0;
        sat_next     = sat_q;
        freq_ok_next = freq_ok_q;
        cnt_next     = cnt_q;
        err_next     = err_q;
        settle_next  = settle_q;
`ifdef PPM_FLF_TIMEOUT_EN
        wd_next      = wd_q;
        timeout_next = timeout_q;
`endif
        if (!enable) begin
            state_next   = ST_IDLE;
            freq_ok_next = 1'b0;
            cnt_next     = '0;
            settle_next  = '0;
`ifdef PPM_FLF_TIMEOUT_EN
            wd_next      = '0;
            timeout_next = 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: state_next = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (meas_valid && !meas_bad) begin
                        err_next = meas_err;
                        if (in_tol) begin
                            cnt_next = cnt_q + CNT_W'(1);
                            if (cnt_q == LOCK_LAST) begin
                                state_next   = ST_LOCKED;
                                freq_ok_next = 1'b1;
                            end
                        end else begin
                            cnt_next    = '0;
                            dac_next    = step_code;
                            sat_next    = step_sat;
                            update_next = 1'b1;
                            settle_next = '0;
                            state_next  = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_next = '0;
                        state_next  = ST_ACQUIRE;
                    end else begin
                        settle_next = settle_q + SET_W'(1);
                    end
                end
                ST_LOCKED: freq_ok_next = 1'b1;
                default: state_next = ST_IDLE;
            endcase
`ifdef PPM_FLF_TIMEOUT_EN
            // Watchdog runs only while hunting; expiry re-centres the DAC and restarts settling.
            if (state == ST_ACQUIRE || state == ST_SETTLE) begin
                if (wd_q == WD_LAST) begin
                    wd_next      = '0;
                    dac_next     = DAC_MID;
                    update_next  = 1'b1;
                    cnt_next     = '0;
                    settle_next  = '0;
                    freq_ok_next = 1'b0;
                    state_next   = ST_SETTLE;
                    timeout_next = 1'b1;
                end else begin
                    wd_next = wd_q + WD_W'(1);
                end
            end else begin
                wd_next = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dac_q     <= DAC_MID;
            update_q  <= 1'b0;
            sat_q     <= 1'b0;
            freq_ok_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= '0;
            settle_q  <= '0;
`ifdef PPM_FLF_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            dac_q     <= dac_next;
            update_q  <= update_next;
            sat_q     <= sat_next;
            freq_ok_q <= freq_ok_next;
            cnt_q     <= cnt_next;
            err_q     <= err_next;
            settle_q  <= settle_next;
`ifdef PPM_FLF_TIMEOUT_EN
            wd_q      <= wd_next;
            timeout_q <= timeout_next;
`endif
        end
    end

`ifdef PPM_FLF_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign dac_code            = dac_q;
    assign dac_update          = update_q;
    assign dac_sat             = sat_q;
    assign freq_ok             = freq_ok_q;
    assign FLF_state_SC        = state;
    assign FLF_in_tol_count_SC = cnt_q;
    assign FLF_error_SC        = err_q;

endmodule
